// File: rtl/calculator_pkg.sv
// Shared constants for the calculator datapath.
// Provides the default data width and the adder segment-count helper.
package calculator_pkg;

    localparam int DATA_W = 32;

    // Number of pipeline segments for a given width and segment size
    function automatic int num_seg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG_W-bit ripple-carry segment.
// Ports: a, b operands; cin carry in; s sum; cout carry out;
//        c_msb_in carry into the top bit (for signed overflow).
module adder_seg #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SEG_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (c[i]),
            .s_o (s[i]),
            .c_o (c[i+1])
        );
    end

    assign cout     = c[SEG_W];
    assign c_msb_in = c[SEG_W-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
// Ports: a_i, b_i, c_i operand/carry in; s_o sum; c_o carry out.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract, one SEG_W-bit ripple segment per stage,
// with a valid/ready handshake and a global stall.
// Ports: clk_i, rst_i (sync, active high); valid_i/ready_o/a_i/b_i/
//        cin_i/sub_i input beat; valid_o/ready_i/sum_o/cout_o/ovf_o
//        result beat.
module pipelined_adder
    import calculator_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SEG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int NUM_SEG = num_seg(WIDTH, SEG_W);

    if (WIDTH % SEG_W != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be a multiple of SEG_W");
    end

    logic en;
    logic seg_ovf [NUM_SEG];
    logic ovf_d;
    logic ovf_q;

    // Whole pipeline moves together; it only holds when the
    // output register is full and downstream refuses it.
    assign en      = !valid_o || ready_i;
    assign ready_o = en;

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        // REM: operand bits still to be summed entering stage k.
        // DONE: sum bits complete after stage k.
        localparam int REM  = WIDTH - k * SEG_W;
        localparam int DONE = (k + 1) * SEG_W;

        logic [REM-1:0]   a_src;
        logic [REM-1:0]   b_src;
        logic             c_src;
        logic             v_src;
        logic [SEG_W-1:0] seg_s;
        logic             seg_c;
        logic             seg_cm;
        logic [DONE-1:0]  s_d;
        logic [DONE-1:0]  s_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_in
            // Subtract is a + ~b + 1; carry-in is ignored then.
            assign a_src = a_i;
            assign b_src = sub_i ? ~b_i : b_i;
            assign c_src = sub_i | cin_i;
            assign v_src = valid_i;
            assign s_d   = seg_s;
        end else begin : g_mid
            assign a_src = g_stage[k-1].g_fwd.a_q;
            assign b_src = g_stage[k-1].g_fwd.b_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
            assign s_d   = {seg_s, g_stage[k-1].s_q};
        end

        adder_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a        (a_src[SEG_W-1:0]),
            .b        (b_src[SEG_W-1:0]),
            .cin      (c_src),
            .s        (seg_s),
            .cout     (seg_c),
            .c_msb_in (seg_cm)
        );

        assign seg_ovf[k] = seg_cm ^ seg_c;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_src;
                c_q <= seg_c;
                s_q <= s_d;
            end
        end

        // Skew: only the not-yet-summed upper segments move on.
        if (k < NUM_SEG - 1) begin : g_fwd
            logic [REM-SEG_W-1:0] a_q;
            logic [REM-SEG_W-1:0] b_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_src[REM-1:SEG_W];
                    b_q <= b_src[REM-1:SEG_W];
                end
            end
        end
    end

    assign ovf_d = seg_ovf[NUM_SEG-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign valid_o = g_stage[NUM_SEG-1].v_q;
    assign sum_o   = g_stage[NUM_SEG-1].s_q;
    assign cout_o  = g_stage[NUM_SEG-1].c_q;
    assign ovf_o   = ovf_q;

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the fixed 32-bit ripple adder in the calculator datapath.
- Splits a WIDTH-bit add/subtract into NUM_SEG = WIDTH/SEG_W ripple segments, one segment per pipeline stage, so the critical path is bounded by SEG_W full adders.
- Adds carry-in, carry-out, signed-overflow and subtract mode.
- Uses a valid/ready handshake so the calculator controller can stream operands and absorb back-pressure.

Parameters:
- WIDTH, default DATA_W (32): operand and result width.
- SEG_W, default 8: bits summed per pipeline stage. WIDTH % SEG_W must be 0; otherwise elaboration fails via $error.

Ports:
- clk_i  in  1  Single clock; all state updates on the rising edge.
- rst_i  in  1  Synchronous, active-high reset.
- valid_i  in  1  Operand beat valid.
- ready_o  out  1  Block can accept a beat this cycle.
- a_i  in  WIDTH  Operand A.
- b_i  in  WIDTH  Operand B.
- cin_i  in  1  Carry-in. Ignored when sub_i=1.
- sub_i  in  1  1: compute a_i - b_i. 0: compute a_i + b_i + cin_i.
- valid_o  out  1  Result beat valid.
- ready_i  in  1  Downstream accepts the result.
- sum_o  out  WIDTH  Result, modulo 2^WIDTH.
- cout_o  out  1  Carry out of the MSB. For subtract, 1 means no borrow.
- ovf_o  out  1  Two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, applied on clk_i rising edge while rst_i=1.
- Reset values:
  - all stage valid bits 0
  - valid_o=0, sum_o=0, cout_o=0, ovf_o=0
  - data registers may also be cleared to 0
- Beat transfer: a beat is accepted when valid_i && ready_o, and delivered when valid_o && ready_i.
- Global stall: enable = !valid_o || ready_i, and ready_o = enable.
  - When enable=0, every stage register holds. sum_o, cout_o and ovf_o must stay stable while valid_o=1 and ready_i=0.
- Bubbles: a stage advances its valid bit even when it is 0, so gaps do not block the pipeline.
- Latency: exactly NUM_SEG cycles from acceptance to valid_o with no stall; each stall cycle adds one.
- Throughput: one beat per cycle when ready_i is held high.
- Operand preparation at stage 0:
  - b_eff = sub_i ? ~b_i : b_i
  - c0 = sub_i ? 1 : cin_i
- Stage k (0..NUM_SEG-1):
  - adds segment k of a and b_eff plus the carry registered from stage k-1 (c0 for k=0)
  - registers the SEG_W-bit partial sum and the carry-out
- Skew and deskew:
  - Upper, not-yet-summed operand segments are carried forward in pipeline registers (skew).
  - Completed lower sum segments are carried forward until the final stage (deskew).
  - All segments of one beat appear on sum_o in the same cycle.
- Outputs:
  - cout_o = carry out of the last segment.
  - ovf_o = carry into the MSB XOR carry out of the MSB, computed in the last stage.
- Beat ordering: beats leave strictly in acceptance order; there is no reordering and no drop.
- Simultaneous accept and deliver in the same cycle is legal at full throughput.
- Reset mid-operation: in-flight beats are discarded. valid_o=0 on the cycle after rst_i is sampled high; no stale result may emerge afterwards.
- NUM_SEG=1: degenerates to a single registered adder with 1-cycle latency, same handshake.

Decomposition:
- calculator_pkg:
  - DATA_W, the default for WIDTH
  - a localparam helper or function computing NUM_SEG
- Sub-module adder_seg #(SEG_W):
  - combinational ripple of SEG_W full_adder instances
  - ports a, b (SEG_W), cin, s (SEG_W), cout, plus c_msb_in (the carry into the top bit, used for ovf_o)
  - instantiated NUM_SEG times in a generate loop; pipeline registers live in pipelined_adder

Test Plan (WIDTH=32, SEG_W=8, latency 4, ready_i=1 unless stated):
- a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 4 cycles later valid_o=1, sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1.
- a=5, b=7, sub=1, cin_i=1 (must be ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Also a=7, b=5, sub=1 -> sum=2, cout=1.
- a=0x000000FF, b=0, cin=1 -> sum=0x00000100, confirming the carry crosses a segment boundary through the stage register.
- Stream 6 beats back-to-back with sums 1..6, ready_i=0 for 3 cycles mid-stream:
  - ready_o=0 during the stall
  - sum_o stable while stalled
  - all 6 results delivered in order, none lost or duplicated
- Accept 2 beats, assert rst_i for 1 cycle -> valid_o=0 from the next cycle; no result appears within 8 cycles; a new beat 3+4 then returns 7 after 4 cycles.
